// File: rtl/usart_rx_fifo_if.sv
// Receive-side consumer interface of usart_rx_fifo: head-of-FIFO entry,
// occupancy, overrun flag and the consumer's ready/accept strobe.
// The receiver drives the master modport, the consumer uses the slave modport.
interface usart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       rx_data;
  logic             rx_parity_error;
  logic             rx_framing_error;
  logic             rx_valid;
  logic             rx_ready;
  logic [CNT_W-1:0] rx_count;
  logic             overrun;

  modport master (
    output rx_data,
    output rx_parity_error,
    output rx_framing_error,
    output rx_valid,
    output rx_count,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_parity_error,
    input  rx_framing_error,
    input  rx_valid,
    input  rx_count,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/usart_rx_fifo.sv
// USART receiver with a first-word-fall-through receive FIFO.
// The serial line is synchronized, frames are sampled mid-bit with a
// down-counting bit timer, and completed frames (data plus parity/framing
// flags) are queued for the consumer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | line idle, waiting for a falling edge (start bit)
// START      | half-bit wait, then confirm the start bit (glitch reject)
// DATA       | sampling data bits, LSB first, one per bit period
// PARITY     | sampling the parity bit (even/odd modes only)
// STOP       | sampling one or two stop bits, then requesting the push
// BREAK_WAIT | line still low after the frame; wait for it to go high
module usart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int CPB_WIDTH  = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CPB_WIDTH-1:0] clocks_per_bit,
  input  logic [1:0]           data_bits,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx_pin,
  usart_rx_fifo_if.master      rx_if
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } state_t;

  // synchronizer
  logic rx_meta;
  logic rx_s;

  // frame receiver
  state_t               state;
  logic [CPB_WIDTH-1:0] timer;
  logic [CPB_WIDTH-1:0] cpb_r;
  logic [CPB_WIDTH-1:0] cpb_eff;
  logic [1:0]           bits_r;
  logic [1:0]           pmode_r;
  logic                 two_stop_r;
  logic [2:0]           bit_idx;
  logic [2:0]           last_idx;
  logic                 stop_idx;
  logic [7:0]           frame_data;
  logic                 par_acc;
  logic                 par_err;
  logic                 frm_err;
  logic                 push_pend;
  logic                 parity_en;

  // receive FIFO
  logic [9:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overrun_r;
  logic             full;
  logic             valid;
  logic             pop;
  logic             do_push;
  logic [9:0]       head;

  // Bit periods shorter than 4 clocks leave no room for a mid-bit sample.
  assign cpb_eff   = (clocks_per_bit < CPB_WIDTH'(4)) ? CPB_WIDTH'(4) : clocks_per_bit;
  assign last_idx  = {1'b0, bits_r} + 3'd4;
  assign parity_en = pmode_r[0] ^ pmode_r[1];

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_s    <= rx_meta;
    end
  end

  // Frame receiver FSM: bit timing, data/parity/stop sampling, push request.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      cpb_r      <= '0;
      bits_r     <= '0;
      pmode_r    <= '0;
      two_stop_r <= 1'b0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      frame_data <= '0;
      par_acc    <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      push_pend  <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            // Configuration is frozen for the whole frame from here on.
            cpb_r      <= cpb_eff;
            bits_r     <= data_bits;
            pmode_r    <= parity_mode;
            two_stop_r <= two_stop;
            timer      <= (cpb_eff >> 1) - CPB_WIDTH'(1);
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            frame_data <= '0;
            par_acc    <= 1'b0;
            par_err    <= 1'b0;
            frm_err    <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (timer != '0) begin
            timer <= timer - CPB_WIDTH'(1);
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            timer <= cpb_r - CPB_WIDTH'(1);
            state <= DATA;
          end
        end
        DATA: begin
          if (timer != '0) begin
            timer <= timer - CPB_WIDTH'(1);
          end else begin
            frame_data[bit_idx] <= rx_s;
            par_acc             <= par_acc ^ rx_s;
            timer               <= cpb_r - CPB_WIDTH'(1);
            if (bit_idx == last_idx) begin
              state <= parity_en ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (timer != '0) begin
            timer <= timer - CPB_WIDTH'(1);
          end else begin
            // Even mode expects an XOR of 0, odd mode (2) an XOR of 1.
            par_err <= par_acc ^ rx_s ^ (pmode_r == 2'd2);
            timer   <= cpb_r - CPB_WIDTH'(1);
            state   <= STOP;
          end
        end
        STOP: begin
          if (timer != '0) begin
            timer <= timer - CPB_WIDTH'(1);
          end else begin
            if (!rx_s) begin
              frm_err <= 1'b1;
            end
            if (two_stop_r && !stop_idx) begin
              stop_idx <= 1'b1;
              timer    <= cpb_r - CPB_WIDTH'(1);
            end else begin
              // A low final stop bit means a break; wait it out so it
              // yields a single entry.
              push_pend <= 1'b1;
              state     <= rx_s ? IDLE : BREAK_WAIT;
            end
          end
        end
        BREAK_WAIT: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign valid   = (count != '0);
  assign pop     = valid && rx_if.rx_ready;
  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign do_push = push_pend && (!full || pop);

  // FIFO pointers, occupancy and the sticky overrun flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_r <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        overrun_r <= 1'b0;
      end else if (push_pend && full) begin
        overrun_r <= 1'b1;
      end
      case ({do_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: {framing_error, parity_error, data}; contents need no reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= {frm_err, par_err, frame_data};
    end
  end

  // Head entry shown combinationally; forced to zero while empty.
  assign head                   = mem[rd_ptr];
  assign rx_if.rx_valid         = valid;
  assign rx_if.rx_data          = valid ? head[7:0] : 8'h00;
  assign rx_if.rx_parity_error  = valid ? head[8] : 1'b0;
  assign rx_if.rx_framing_error = valid ? head[9] : 1'b0;
  assign rx_if.rx_count         = count;
  assign rx_if.overrun          = overrun_r;

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Self-checking bench for usart_rx_fifo. Frames are serialized from a bench
// bit list; every frame the bench expects to be stored is queued as
// {framing_error, parity_error, data} and compared when the DUT's head is popped.
module tb_usart_rx_fifo;
  localparam int DEPTH = 4;
  localparam int CPBW  = 12;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [CPBW-1:0] clocks_per_bit = 12'd32;
  logic [1:0]      data_bits = 2'd3;
  logic [1:0]      parity_mode = 2'd0;
  logic            two_stop = 1'b0;
  logic            rx_pin = 1'b1;

  usart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rx_if ();

  usart_rx_fifo #(.FIFO_DEPTH(DEPTH), .CPB_WIDTH(CPBW)) dut (
    .clock          (clock),
    .reset          (reset),
    .clocks_per_bit (clocks_per_bit),
    .data_bits      (data_bits),
    .parity_mode    (parity_mode),
    .two_stop       (two_stop),
    .rx_pin         (rx_pin),
    .rx_if          (rx_if)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  int         cpb = 32;
  logic [9:0] exp_q[$];
  logic       ovr_exp = 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Serialize one frame at the bench bit period and model its FIFO effect.
  task automatic send_frame(input logic [7:0] d, input int nbits, input int pmode,
                            input bit two, input bit bad_par, input bit stop2_val,
                            input bit scramble);
    logic [15:0] bits;
    logic [7:0]  mask;
    logic        par;
    logic        pe;
    logic        fe;
    int          n;
    bits = '0;
    par  = 1'b0;
    pe   = 1'b0;
    fe   = 1'b0;
    mask = 8'hFF >> (8 - nbits);
    clocks_per_bit = CPBW'(cpb < 4 ? 2 : cpb);
    data_bits      = 2'(nbits - 5);
    parity_mode    = 2'(pmode);
    two_stop       = two;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nbits; i++) begin
      bits[n] = d[i];
      par     = par ^ d[i];
      n++;
    end
    if (pmode == 1 || pmode == 2) begin
      bits[n] = (pmode == 1) ? par : ~par;
      if (bad_par) bits[n] = ~bits[n];
      pe = bad_par;
      n++;
    end
    bits[n] = 1'b1;
    n++;
    if (two) begin
      bits[n] = stop2_val;
      fe = ~stop2_val;
      n++;
    end
    for (int i = 0; i < n; i++) begin
      rx_pin = bits[i];
      if (scramble && i == 2) begin
        data_bits      = 2'd0;
        parity_mode    = 2'd1;
        two_stop       = ~two;
        clocks_per_bit = 12'd100;
      end
      tick(cpb);
    end
    rx_pin         = 1'b1;
    clocks_per_bit = CPBW'(cpb < 4 ? 2 : cpb);
    data_bits      = 2'(nbits - 5);
    parity_mode    = 2'(pmode);
    two_stop       = two;
    tick(4);
    if (exp_q.size() < DEPTH) exp_q.push_back({fe, pe, d & mask});
    else ovr_exp = 1'b1;
  endtask

  task automatic do_pop();
    rx_if.rx_ready = 1'b1;
    tick(1);
    rx_if.rx_ready = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    ovr_exp = 1'b0;
  endtask

  task automatic test_reset();
    rx_if.rx_ready = 1'b1;
    reset = 1'b0;
    tick(3);
    checks++;
    if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_if.rx_valid); end
    checks++;
    if (rx_if.rx_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", rx_if.rx_count); end
    checks++;
    if ({rx_if.overrun, rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ovr=%b fe=%b pe=%b data=%h want all 0", rx_if.overrun,
               rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data);
    end
    rx_if.rx_ready = 1'b0;
    reset = 1'b1;
    tick(3);
    checks++;
    if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL ready_when_empty: got valid=%b want 0", rx_if.rx_valid); end
  endtask

  task automatic test_single_frame();
    cpb = 32;
    send_frame(8'h75, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rx_if.rx_count !== CNT_W'(1)) begin errors++; $display("FAIL single_count: got %0d want 1", rx_if.rx_count); end
    checks++;
    if ({rx_if.rx_valid, rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data} !== {1'b1, exp_q[0]}) begin
      errors++;
      $display("FAIL single_head: got v=%b fe=%b pe=%b data=%h want v=1 %h", rx_if.rx_valid,
               rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data, exp_q[0]);
    end
  endtask

  task automatic test_two_frames();
    send_frame(8'h8A, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    while (exp_q.size() != 0) begin
      checks++;
      if (rx_if.rx_count !== CNT_W'(exp_q.size())) begin
        errors++; $display("FAIL order_count: got %0d want %0d", rx_if.rx_count, exp_q.size());
      end
      checks++;
      if ({rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data} !== exp_q[0]) begin
        errors++; $display("FAIL order_head: got %h want %h", {rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data}, exp_q[0]);
      end
      do_pop();
    end
    checks++;
    if (rx_if.rx_count !== '0 || rx_if.rx_valid !== 1'b0) begin
      errors++; $display("FAIL order_empty: got count=%0d valid=%b want 0 0", rx_if.rx_count, rx_if.rx_valid);
    end
  endtask

  task automatic test_glitch();
    rx_pin = 1'b0;
    tick(10);
    rx_pin = 1'b1;
    tick(3 * cpb);
    checks++;
    if (rx_if.rx_valid !== 1'b0 || rx_if.rx_count !== '0) begin
      errors++; $display("FAIL glitch_nopush: got valid=%b count=%0d want 0 0", rx_if.rx_valid, rx_if.rx_count);
    end
    send_frame(8'h3C, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({rx_if.rx_valid, rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data} !== {1'b1, exp_q[0]}) begin
      errors++; $display("FAIL glitch_next: got data=%h want %h", rx_if.rx_data, exp_q[0][7:0]);
    end
    do_pop();
  endtask

  task automatic test_formats();
    send_frame(8'h41, 7, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h2D, 6, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h13, 5, 3, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'h6B, 8, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (rx_if.rx_count !== CNT_W'(4)) begin errors++; $display("FAIL formats_count: got %0d want 4", rx_if.rx_count); end
    while (exp_q.size() != 0) begin
      checks++;
      if ({rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data} !== exp_q[0]) begin
        errors++; $display("FAIL formats_head: got %h want %h", {rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data}, exp_q[0]);
      end
      do_pop();
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_frame(8'(i * 8'h11), 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rx_if.rx_count !== CNT_W'(exp_q.size()) || rx_if.overrun !== ovr_exp) begin
      errors++; $display("FAIL overrun_set: got count=%0d ovr=%b want %0d %b", rx_if.rx_count, rx_if.overrun, exp_q.size(), ovr_exp);
    end
    checks++;
    if (rx_if.rx_data !== exp_q[0][7:0]) begin errors++; $display("FAIL overrun_head: got %h want %h", rx_if.rx_data, exp_q[0][7:0]); end
    do_pop();
    checks++;
    if (rx_if.overrun !== 1'b0 || rx_if.rx_count !== CNT_W'(3)) begin
      errors++; $display("FAIL overrun_clear: got ovr=%b count=%0d want 0 3", rx_if.overrun, rx_if.rx_count);
    end
    send_frame(8'h66, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rx_if.rx_count !== CNT_W'(4)) begin errors++; $display("FAIL refill_count: got %0d want 4", rx_if.rx_count); end
  endtask

  // The push of an 8N1 frame at 32 clocks/bit lands 308 edges after the
  // start bit is driven (2 sync + 1 detect + 16 half-bit + 9*32 bits + 1).
  task automatic test_back_to_back();
    fork
      send_frame(8'h77, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        repeat (307) @(posedge clock);
        #1;
        checks++;
        if (rx_if.rx_data !== exp_q[0][7:0] || rx_if.rx_count !== CNT_W'(4)) begin
          errors++; $display("FAIL b2b_pre: got data=%h count=%0d want %h 4", rx_if.rx_data, rx_if.rx_count, exp_q[0][7:0]);
        end
        do_pop();
        checks++;
        if (rx_if.rx_count !== CNT_W'(4) || rx_if.overrun !== 1'b0) begin
          errors++; $display("FAIL b2b_same_edge: got count=%0d ovr=%b want 4 0", rx_if.rx_count, rx_if.overrun);
        end
      end
    join
    checks++;
    if (rx_if.rx_count !== CNT_W'(exp_q.size()) || rx_if.overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_after: got count=%0d ovr=%b want %0d 0", rx_if.rx_count, rx_if.overrun, exp_q.size());
    end
    while (exp_q.size() != 0) begin
      checks++;
      if ({rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data} !== exp_q[0]) begin
        errors++; $display("FAIL b2b_drain: got %h want %h", {rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data}, exp_q[0]);
      end
      do_pop();
    end
  endtask

  task automatic test_break();
    rx_pin = 1'b0;
    tick(30 * cpb);
    rx_pin = 1'b1;
    tick(8);
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    checks++;
    if (rx_if.rx_count !== CNT_W'(1)) begin errors++; $display("FAIL break_count: got %0d want 1", rx_if.rx_count); end
    send_frame(8'hC3, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    while (exp_q.size() != 0) begin
      checks++;
      if ({rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data} !== exp_q[0]) begin
        errors++; $display("FAIL break_entry: got %h want %h", {rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data}, exp_q[0]);
      end
      do_pop();
    end
  endtask

  task automatic test_mid_reset();
    rx_pin = 1'b0;
    tick(cpb * 3);
    rx_pin = 1'b1;
    tick(cpb);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(cpb * 12);
    checks++;
    if (rx_if.rx_valid !== 1'b0 || rx_if.rx_count !== '0) begin
      errors++; $display("FAIL midreset_discard: got valid=%b count=%0d want 0 0", rx_if.rx_valid, rx_if.rx_count);
    end
    send_frame(8'h5A, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data} !== exp_q[0]) begin
      errors++; $display("FAIL midreset_next: got %h want %h", {rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data}, exp_q[0]);
    end
    do_pop();
  endtask

  task automatic test_cfg_latch();
    send_frame(8'h96, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({rx_if.rx_valid, rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data} !== {1'b1, exp_q[0]}) begin
      errors++; $display("FAIL cfg_latched: got data=%h fe=%b pe=%b want %h", rx_if.rx_data,
                         rx_if.rx_framing_error, rx_if.rx_parity_error, exp_q[0]);
    end
    do_pop();
  endtask

  task automatic test_min_cpb();
    cpb = 4;
    send_frame(8'hA5, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({rx_if.rx_valid, rx_if.rx_framing_error, rx_if.rx_parity_error, rx_if.rx_data} !== {1'b1, exp_q[0]}) begin
      errors++; $display("FAIL min_cpb: got data=%h fe=%b pe=%b want %h", rx_if.rx_data,
                         rx_if.rx_framing_error, rx_if.rx_parity_error, exp_q[0]);
    end
    do_pop();
    cpb = 32;
  endtask

  initial begin
    rx_if.rx_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_two_frames();
    test_glitch();
    test_formats();
    test_overrun();
    test_back_to_back();
    test_break();
    test_mid_reset();
    test_cfg_latch();
    test_min_cpb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
